// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache tag path:
// geometry, the {valid, tag} entry layout, CACOP encodings and the writer FSM states.
package icache_pkg;

    localparam int INDEX_W = 7;
    localparam int TAG_W   = 20;
    localparam int WAYS    = 2;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ENTRY_W = TAG_W + 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        CACOP_IDX_INV_WAY = 2'b00,
        CACOP_IDX_INV_ALL = 2'b01,
        CACOP_HIT_INV     = 2'b10,
        CACOP_RESERVED    = 2'b11
    } cacop_op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CMP
    } state_e;

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
        logic [WAYS-1:0] oh;
        oh      = '0;
        oh[way] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/icache_tag_writer_if.sv
// Request handshakes and tag-RAM ports of the icache tag writer.
// The slave modport is the writer itself; master is its environment.
interface icache_tag_writer_if;
    import icache_pkg::*;

    logic                      refill_valid;
    logic                      refill_ready;
    logic [INDEX_W-1:0]        refill_index;
    logic [WAY_W-1:0]          refill_way;
    logic [TAG_W-1:0]          refill_tag;

    logic                      cacop_valid;
    logic                      cacop_ready;
    logic [1:0]                cacop_op;
    logic [INDEX_W-1:0]        cacop_index;
    logic [WAY_W-1:0]          cacop_way;
    logic [TAG_W-1:0]          cacop_tag;
    logic                      cacop_done;
    logic                      cacop_hit;

    logic                      rd_en;
    logic [INDEX_W-1:0]        rd_index;
    logic [WAYS*ENTRY_W-1:0]   rd_tag;

    logic [WAYS-1:0]           tag_we;
    logic [INDEX_W-1:0]        tag_windex;
    logic [ENTRY_W-1:0]        tag_wdata;
    logic                      init_done;

    modport slave (
        input  refill_valid, refill_index, refill_way, refill_tag,
        input  cacop_valid, cacop_op, cacop_index, cacop_way, cacop_tag,
        input  rd_tag,
        output refill_ready, cacop_ready, cacop_done, cacop_hit,
        output rd_en, rd_index, tag_we, tag_windex, tag_wdata, init_done
    );

    modport master (
        output refill_valid, refill_index, refill_way, refill_tag,
        output cacop_valid, cacop_op, cacop_index, cacop_way, cacop_tag,
        output rd_tag,
        input  refill_ready, cacop_ready, cacop_done, cacop_hit,
        input  rd_en, rd_index, tag_we, tag_windex, tag_wdata, init_done
    );

endinterface

// File: rtl/icache_tag_match.sv
// Per-way hit detection on a packed row of {valid, tag} entries.
// Purely combinational so the lookup path can share it.
module icache_tag_match
    import icache_pkg::*;
(
    input  logic [WAYS*ENTRY_W-1:0] rd_tag_i,
    input  logic [TAG_W-1:0]        cmp_tag_i,
    output logic [WAYS-1:0]         match_o
);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            tag_entry_t entry;
            assign entry       = rd_tag_i[gi*ENTRY_W +: ENTRY_W];
            assign match_o[gi] = entry.valid & (entry.tag == cmp_tag_i);
        end
    endgenerate

endmodule

// File: rtl/icache_tag_writer.sv
// Sequences all icache tag-RAM writes: refills, CACOP invalidates and the clear sweep.
// ICACHE_INIT_SWEEP_EN: when defined, clear every set after reset before taking requests.
module icache_tag_writer
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    icache_tag_writer_if.slave bus
);

`ifdef ICACHE_INIT_SWEEP_EN
    localparam state_e RST_STATE     = ST_INIT;
    localparam logic   RST_INIT_DONE = 1'b0;
`else
    localparam state_e RST_STATE     = ST_IDLE;
    localparam logic   RST_INIT_DONE = 1'b1;
`endif

    state_e             state_q, state_d;
    logic [WAYS-1:0]    tag_we_q, tag_we_d;
    logic [INDEX_W-1:0] windex_q, windex_d;
    tag_entry_t         wdata_q, wdata_d;
    logic               rd_en_q, rd_en_d;
    logic [INDEX_W-1:0] rd_index_q, rd_index_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;
    logic               init_done_q, init_done_d;
    logic [INDEX_W-1:0] lat_index_q, lat_index_d;
    logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
    logic [WAYS-1:0]    match;
    logic               cacop_acc, refill_acc;

    assign bus.cacop_ready  = (state_q == ST_IDLE);
    assign bus.refill_ready = (state_q == ST_IDLE) & ~bus.cacop_valid;
    assign cacop_acc        = bus.cacop_valid & bus.cacop_ready;
    assign refill_acc       = bus.refill_valid & bus.refill_ready;

    icache_tag_match u_match (
        .rd_tag_i  (bus.rd_tag),
        .cmp_tag_i (lat_tag_q),
        .match_o   (match)
    );

`ifdef ICACHE_INIT_SWEEP_EN
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               sweep_last;
    // The last sweep write is the one currently on the bus at the top index.
    assign sweep_last = (&tag_we_q) & (&windex_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_INIT && !sweep_last && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            init_done_q <= RST_INIT_DONE;
            tag_we_q    <= '0;
            windex_q    <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_index_q  <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            lat_index_q <= '0;
            lat_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            tag_we_q    <= tag_we_d;
            windex_q    <= windex_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            rd_index_q  <= rd_index_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            lat_index_q <= lat_index_d;
            lat_tag_q   <= lat_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef ICACHE_INIT_SWEEP_EN
            ST_INIT: if (sweep_last) state_d = ST_IDLE;
`endif
            ST_IDLE: begin
                if (cacop_acc)
                    state_d = (cacop_op_e'(bus.cacop_op) == CACOP_HIT_INV) ? ST_RD : ST_WR;
                else if (refill_acc)
                    state_d = ST_WR;
            end
            ST_WR:   state_d = ST_IDLE;
            ST_RD:   state_d = ST_CMP;
            ST_CMP:  state_d = ST_WR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_we_d    = '0;
        windex_d    = windex_q;
        wdata_d     = wdata_q;
        rd_en_d     = 1'b0;
        rd_index_d  = rd_index_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        init_done_d = init_done_q;
        lat_index_d = lat_index_q;
        lat_tag_d   = lat_tag_q;
        case (state_q)
`ifdef ICACHE_INIT_SWEEP_EN
            ST_INIT: begin
                if (sweep_last) begin
                    init_done_d = 1'b1;
                end else begin
                    tag_we_d = '1;
                    windex_d = cnt_q;
                    wdata_d  = '0;
                end
            end
`endif
            ST_IDLE: begin
                if (cacop_acc) begin
                    case (cacop_op_e'(bus.cacop_op))
                        CACOP_IDX_INV_WAY: begin
                            tag_we_d = way_onehot(bus.cacop_way);
                            windex_d = bus.cacop_index;
                            wdata_d  = '0;
                            done_d   = 1'b1;
                        end
                        CACOP_IDX_INV_ALL: begin
                            tag_we_d = '1;
                            windex_d = bus.cacop_index;
                            wdata_d  = '0;
                            done_d   = 1'b1;
                        end
                        CACOP_HIT_INV: begin
                            rd_en_d     = 1'b1;
                            rd_index_d  = bus.cacop_index;
                            lat_index_d = bus.cacop_index;
                            lat_tag_d   = bus.cacop_tag;
                        end
                        default: done_d = 1'b1;
                    endcase
                end else if (refill_acc) begin
                    tag_we_d = way_onehot(bus.refill_way);
                    windex_d = bus.refill_index;
                    wdata_d  = '{valid: 1'b1, tag: bus.refill_tag};
                end
            end
            // RAM read data is valid here; a miss still completes with no write.
            ST_CMP: begin
                tag_we_d = match;
                windex_d = lat_index_q;
                wdata_d  = '0;
                done_d   = 1'b1;
                hit_d    = |match;
            end
            default: ;
        endcase
    end

    assign bus.tag_we     = tag_we_q;
    assign bus.tag_windex = windex_q;
    assign bus.tag_wdata  = wdata_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_index   = rd_index_q;
    assign bus.cacop_done = done_q;
    assign bus.cacop_hit  = hit_q;
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_icache_tag_writer.sv
// Randomized bench for icache_tag_writer: a behavioural tag RAM plus a cache-content
// reference model predicting every write, read strobe and completion.
module tb_icache_tag_writer;
    import icache_pkg::*;

    localparam int SETS = 1 << INDEX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_tag_writer_if bus ();

    icache_tag_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural tag RAM: one-cycle registered read, per-way write.
    tag_entry_t              ram [WAYS][SETS];
    logic [WAYS*ENTRY_W-1:0] rd_q;
    assign bus.rd_tag = rd_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
`ifdef ICACHE_INIT_SWEEP_EN
                    ram[w][s] <= ENTRY_W'($urandom);
`else
                    ram[w][s] <= '0;
`endif
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.rd_en) rd_q[w*ENTRY_W +: ENTRY_W] <= ram[w][bus.rd_index];
                if (bus.tag_we[w]) ram[w][bus.tag_windex] <= bus.tag_wdata;
            end
        end
    end

    tag_entry_t ref_mem [WAYS][SETS];
    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_ref();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                ref_mem[w][s] = '0;
    endtask

    task automatic check_sweep();
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk);
            check_eq("sweep_we", bus.tag_we, {WAYS{1'b1}});
            check_eq("sweep_idx", bus.tag_windex, i);
            check_eq("sweep_wdata", bus.tag_wdata, 0);
            check_eq("sweep_initdone", bus.init_done, 0);
            check_eq("sweep_cready", bus.cacop_ready, 0);
            check_eq("sweep_rready", bus.refill_ready, 0);
        end
        @(negedge clk);
        check_eq("sweep_end_initdone", bus.init_done, 1);
        check_eq("sweep_end_we", bus.tag_we, 0);
        check_eq("sweep_end_cready", bus.cacop_ready, 1);
    endtask

    // Called at a negedge with the DUT idle; releases rst and checks bring-up.
    task automatic release_reset();
        rst = 1'b0;
`ifdef ICACHE_INIT_SWEEP_EN
        check_sweep();
`else
        #1;
        check_eq("post_rst_initdone", bus.init_done, 1);
        check_eq("post_rst_cready", bus.cacop_ready, 1);
        @(negedge clk);
`endif
        clear_ref();
    endtask

    task automatic do_refill(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way,
                             input logic [TAG_W-1:0] tag);
        logic [WAYS-1:0] exp_we;
        exp_we = '0;
        exp_we[way] = 1'b1;
        n_txn++;
        $display("txn %0d: refill idx=%0h way=%0d tag=%05h", n_txn, idx, way, tag);
        bus.refill_valid = 1'b1;
        bus.refill_index = idx;
        bus.refill_way   = way;
        bus.refill_tag   = tag;
        #1 check_eq("refill_ready", bus.refill_ready, 1);
        @(posedge clk);
        #1;
        bus.refill_valid = 1'b0;
        bus.refill_index = INDEX_W'($urandom);
        bus.refill_way   = WAY_W'($urandom);
        bus.refill_tag   = TAG_W'($urandom);
        @(negedge clk);
        check_eq("refill_we", bus.tag_we, exp_we);
        check_eq("refill_idx", bus.tag_windex, idx);
        check_eq("refill_wdata", bus.tag_wdata, {1'b1, tag});
        check_eq("refill_done", bus.cacop_done, 0);
        check_eq("refill_busy", bus.refill_ready, 0);
        @(negedge clk);
        check_eq("refill_we_clr", bus.tag_we, 0);
        check_eq("refill_back_idle", bus.refill_ready, 1);
        ref_mem[way][idx] = '{valid: 1'b1, tag: tag};
    endtask

    task automatic do_cacop(input logic [1:0] op, input logic [INDEX_W-1:0] idx,
                            input logic [WAY_W-1:0] way, input logic [TAG_W-1:0] tag);
        logic [WAYS-1:0] exp_we;
        logic            exp_hit;
        exp_we  = '0;
        exp_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            case (op)
                2'b00:   exp_we[w] = (w == int'(way));
                2'b01:   exp_we[w] = 1'b1;
                2'b10:   exp_we[w] = ref_mem[w][idx].valid && (ref_mem[w][idx].tag == tag);
                default: exp_we[w] = 1'b0;
            endcase
        end
        if (op == 2'b10) exp_hit = |exp_we;
        n_txn++;
        $display("txn %0d: cacop op=%0d idx=%0h way=%0d tag=%05h -> we=%b hit=%0d",
                 n_txn, op, idx, way, tag, exp_we, exp_hit);
        bus.cacop_valid = 1'b1;
        bus.cacop_op    = op;
        bus.cacop_index = idx;
        bus.cacop_way   = way;
        bus.cacop_tag   = tag;
        #1;
        check_eq("cacop_ready", bus.cacop_ready, 1);
        check_eq("refill_blocked", bus.refill_ready, 0);
        @(posedge clk);
        #1;
        bus.cacop_valid = 1'b0;
        bus.cacop_op    = 2'($urandom);
        bus.cacop_index = INDEX_W'($urandom);
        bus.cacop_way   = WAY_W'($urandom);
        bus.cacop_tag   = TAG_W'($urandom);
        @(negedge clk);
        if (op == 2'b10) begin
            check_eq("hinv_rd_en", bus.rd_en, 1);
            check_eq("hinv_rd_idx", bus.rd_index, idx);
            check_eq("hinv_rd_we", bus.tag_we, 0);
            check_eq("hinv_rd_done", bus.cacop_done, 0);
            @(negedge clk);
            check_eq("hinv_cmp_rd_en", bus.rd_en, 0);
            check_eq("hinv_cmp_we", bus.tag_we, 0);
            check_eq("hinv_cmp_done", bus.cacop_done, 0);
            check_eq("hinv_cmp_cready", bus.cacop_ready, 0);
            @(negedge clk);
        end
        check_eq("cacop_we", bus.tag_we, exp_we);
        check_eq("cacop_done", bus.cacop_done, 1);
        check_eq("cacop_hit", bus.cacop_hit, exp_hit);
        check_eq("cacop_rd_en", bus.rd_en, 0);
        check_eq("cacop_busy", bus.cacop_ready, 0);
        if (op != 2'b11) check_eq("cacop_idx", bus.tag_windex, idx);
        if (exp_we != 0) check_eq("cacop_wdata", bus.tag_wdata, 0);
        @(negedge clk);
        check_eq("cacop_done_pulse", bus.cacop_done, 0);
        check_eq("cacop_we_clr", bus.tag_we, 0);
        check_eq("cacop_back_idle", bus.cacop_ready, 1);
        for (int w = 0; w < WAYS; w++)
            if (exp_we[w]) ref_mem[w][idx] = '0;
    endtask

    initial begin
        logic [INDEX_W-1:0] idx;
        logic [WAY_W-1:0]   way;
        logic [TAG_W-1:0]   tag;
        logic [1:0]         op;
        int                 diff;

        bus.refill_valid = 1'b0;
        bus.refill_index = '0;
        bus.refill_way   = '0;
        bus.refill_tag   = '0;
        bus.cacop_valid  = 1'b0;
        bus.cacop_op     = '0;
        bus.cacop_index  = '0;
        bus.cacop_way    = '0;
        bus.cacop_tag    = '0;
        rd_q             = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_we", bus.tag_we, 0);
        check_eq("rst_windex", bus.tag_windex, 0);
        check_eq("rst_wdata", bus.tag_wdata, 0);
        check_eq("rst_rd_en", bus.rd_en, 0);
        check_eq("rst_rd_index", bus.rd_index, 0);
        check_eq("rst_done", bus.cacop_done, 0);
        check_eq("rst_hit", bus.cacop_hit, 0);
`ifdef ICACHE_INIT_SWEEP_EN
        check_eq("rst_initdone", bus.init_done, 0);
        check_eq("rst_cready", bus.cacop_ready, 0);
`else
        check_eq("rst_initdone", bus.init_done, 1);
`endif
        release_reset();

        do_refill(7'h15, 1'b1, 20'hABCDE);
        // Simultaneous requests: the cacop wins, the refill follows two cycles later.
        bus.refill_valid = 1'b1;
        bus.refill_index = 7'h22;
        bus.refill_way   = 1'b0;
        bus.refill_tag   = 20'h55555;
        do_cacop(2'b01, 7'h03, 1'b0, 20'h0);
        do_refill(7'h22, 1'b0, 20'h55555);
        do_refill(7'h09, 1'b0, 20'h12345);
        do_refill(7'h09, 1'b1, 20'h00000);
        do_cacop(2'b10, 7'h09, 1'b0, 20'h12345);
        do_cacop(2'b10, 7'h09, 1'b0, 20'h12345);
        do_cacop(2'b11, 7'h09, 1'b0, 20'h0);
        do_cacop(2'b00, 7'h15, 1'b1, 20'h0);

        for (int n = 0; n < 300; n++) begin
            idx = INDEX_W'($urandom_range(15));
            way = WAY_W'($urandom_range(WAYS - 1));
            tag = TAG_W'($urandom);
            op  = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b10;
            if (op == 2'b10 && $urandom_range(1) == 1)
                tag = ref_mem[$urandom_range(WAYS - 1)][idx].tag;
            case ($urandom_range(9))
                0, 1, 2, 3: do_refill(idx, way, tag);
                4, 5, 6, 7: do_cacop(op, idx, way, tag);
                default: begin
                    bus.refill_valid = 1'b1;
                    bus.refill_index = INDEX_W'($urandom_range(15));
                    bus.refill_way   = WAY_W'($urandom_range(WAYS - 1));
                    bus.refill_tag   = TAG_W'($urandom);
                    do_cacop(op, idx, way, tag);
                    do_refill(bus.refill_index, bus.refill_way, bus.refill_tag);
                end
            endcase
            if ($urandom_range(3) == 0) @(negedge clk);
        end

        diff = 0;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                if (ram[w][s] !== ref_mem[w][s]) diff++;
        check_eq("ram_contents_diff", diff, 0);

        // Reset while a hit-invalidate sits in its compare cycle.
        do_refill(7'h05, 1'b0, 20'hCAFE1);
        n_txn++;
        $display("txn %0d: hit-inv idx=05 aborted by reset in compare", n_txn);
        bus.cacop_valid = 1'b1;
        bus.cacop_op    = 2'b10;
        bus.cacop_index = 7'h05;
        bus.cacop_tag   = 20'hCAFE1;
        @(posedge clk);
        #1 bus.cacop_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_rd_en", bus.rd_en, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_we", bus.tag_we, 0);
        check_eq("abort_done", bus.cacop_done, 0);
        check_eq("abort_windex", bus.tag_windex, 0);
        @(negedge clk);
        check_eq("abort_we_late", bus.tag_we, 0);
        check_eq("abort_done_late", bus.cacop_done, 0);
        release_reset();
        do_refill(7'h05, 1'b1, 20'h0BEEF);
        do_cacop(2'b10, 7'h05, 1'b0, 20'hCAFE1);
        do_cacop(2'b10, 7'h05, 1'b0, 20'h0BEEF);

        diff = 0;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                if (ram[w][s] !== ref_mem[w][s]) diff++;
        check_eq("ram_contents_diff_final", diff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
